// File: rtl/op2_operand_stage_pkg.sv
// Shared operand-2 select codes and default widths for the execute-stage operand path.
package op2_operand_stage_pkg;

  localparam int unsigned OP2_DATA_W       = 8;
  localparam int unsigned OP2_NUM_BIT_SRC  = 3;
  localparam int unsigned OP2_NUM_WORD_SRC = 2;
  localparam int unsigned OP2_SEL_W        = 3;
  localparam int unsigned OP2_IDX_W        = 3;
  localparam int unsigned OP2_ERR_W        = 8;

  // Legacy op2MuxSel encodings map one-to-one onto these codes.
  typedef enum logic [OP2_SEL_W-1:0] {
    OP2_SEL_INPUT   = 3'd0,
    OP2_SEL_OUTPUT  = 3'd1,
    OP2_SEL_BITRAM  = 3'd2,
    OP2_SEL_BYTERAM = 3'd3,
    OP2_SEL_IMM     = 3'd4
  } op2_sel_e;

endpackage

// File: rtl/op2_src_decode.sv
// Combinational operand-2 source decode: select, optional bit extraction, negation, illegal flag.
module op2_src_decode
  import op2_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W       = OP2_DATA_W,
  parameter int unsigned NUM_BIT_SRC  = OP2_NUM_BIT_SRC,
  parameter int unsigned NUM_WORD_SRC = OP2_NUM_WORD_SRC,
  parameter int unsigned SEL_W        = OP2_SEL_W,
  parameter int unsigned IDX_W        = OP2_IDX_W
) (
  input  logic [SEL_W-1:0]               sel,
  input  logic [NUM_BIT_SRC-1:0]         bit_src,
  input  logic [NUM_WORD_SRC*DATA_W-1:0] word_src,
  input  logic                           extract,
  input  logic [IDX_W-1:0]               bit_idx,
  input  logic                           negate,
  output logic [DATA_W-1:0]              value,
  output logic                           is_bit,
  output logic                           illegal
);

  logic              bit_hit;
  logic              word_hit;
  logic              idx_ok;
  logic              src_bit;
  logic              ext_bit;
  logic [DATA_W-1:0] word;

  always_comb begin
    bit_hit  = 1'b0;
    word_hit = 1'b0;
    idx_ok   = 1'b0;
    src_bit  = 1'b0;
    ext_bit  = 1'b0;
    word     = '0;
    for (int unsigned k = 0; k < NUM_BIT_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        bit_hit = 1'b1;
        src_bit = bit_src[k];
      end
    end
    for (int unsigned j = 0; j < NUM_WORD_SRC; j++) begin
      if (sel == SEL_W'(NUM_BIT_SRC + j)) begin
        word_hit = 1'b1;
        word     = word_src[j*DATA_W +: DATA_W];
      end
    end
    // Index compare loop rather than a variable part-select so bit_idx >= DATA_W is caught.
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (bit_idx == IDX_W'(i)) begin
        idx_ok  = 1'b1;
        ext_bit = word[i];
      end
    end
  end

  always_comb begin
    value   = '0;
    is_bit  = 1'b0;
    illegal = 1'b0;
    if (bit_hit) begin
      value  = DATA_W'(src_bit ^ negate);
      is_bit = 1'b1;
    end else if (word_hit) begin
      if (extract) begin
        if (idx_ok) begin
          value  = DATA_W'(ext_bit ^ negate);
          is_bit = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end else begin
        value = negate ? ~word : word;
      end
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/op2_operand_stage.sv
// Operand-2 pipeline register with flush/stall/load priority and saturating illegal-select counter.
module op2_operand_stage
  import op2_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W       = OP2_DATA_W,
  parameter int unsigned NUM_BIT_SRC  = OP2_NUM_BIT_SRC,
  parameter int unsigned NUM_WORD_SRC = OP2_NUM_WORD_SRC,
  parameter int unsigned SEL_W        = OP2_SEL_W,
  parameter int unsigned IDX_W        = OP2_IDX_W,
  parameter int unsigned ERR_W        = OP2_ERR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sel_valid,
  input  logic [SEL_W-1:0]               sel,
  input  logic [NUM_BIT_SRC-1:0]         bit_src,
  input  logic [NUM_WORD_SRC*DATA_W-1:0] word_src,
  input  logic                           extract,
  input  logic [IDX_W-1:0]               bit_idx,
  input  logic                           negate,
  input  logic                           stall,
  input  logic                           flush,
  output logic [DATA_W-1:0]              op2_out,
  output logic                           op2_valid,
  output logic                           op2_is_bit,
  output logic                           sel_err,
  output logic [ERR_W-1:0]               err_count
);

  logic [DATA_W-1:0] dec_value;
  logic              dec_is_bit;
  logic              dec_illegal;

  logic [DATA_W-1:0] op2_d, op2_q;
  logic              valid_d, valid_q;
  logic              is_bit_d, is_bit_q;
  logic              err_d, err_q;
  logic [ERR_W-1:0]  cnt_d, cnt_q;

  op2_src_decode #(
    .DATA_W       (DATA_W),
    .NUM_BIT_SRC  (NUM_BIT_SRC),
    .NUM_WORD_SRC (NUM_WORD_SRC),
    .SEL_W        (SEL_W),
    .IDX_W        (IDX_W)
  ) u_decode (
    .sel      (sel),
    .bit_src  (bit_src),
    .word_src (word_src),
    .extract  (extract),
    .bit_idx  (bit_idx),
    .negate   (negate),
    .value    (dec_value),
    .is_bit   (dec_is_bit),
    .illegal  (dec_illegal)
  );

  always_comb begin
    op2_d    = op2_q;
    valid_d  = valid_q;
    is_bit_d = is_bit_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (stall) begin
      // full hold, sel_err included
    end else if (sel_valid) begin
      if (dec_illegal) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        op2_d    = dec_value;
        is_bit_d = dec_is_bit;
        valid_d  = 1'b1;
        err_d    = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op2_q    <= '0;
      valid_q  <= 1'b0;
      is_bit_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      op2_q    <= op2_d;
      valid_q  <= valid_d;
      is_bit_q <= is_bit_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign op2_out    = op2_q;
  assign op2_valid  = valid_q;
  assign op2_is_bit = is_bit_q;
  assign sel_err    = err_q;
  assign err_count  = cnt_q;

endmodule
